ras_ss_checker: RTL and testbench

//  Producer/consumer front-end for the RAS shadow stack. Takes committed call/return events from the commit stage.

---
 rtl/ras_ss_checker.sv | 125 ++++++++++++
 tb/tb_ras_ss_checker.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ss_checker.sv
// Commit-side checker for the return-address shadow stack: pushes link addresses on calls,
// pops and compares on returns, and reports violations through a valid/ready alarm port.
module ras_ss_checker #(
  parameter int ADDR_W    = 64,
  parameter int CNT_W     = 16,
  parameter bit OVF_ALARM = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_evt_valid,
  input  logic              i_evt_is_ret,
  input  logic [ADDR_W-1:0] i_evt_addr,
  output logic              o_evt_ready,
  output logic              o_ss_push,
  output logic [ADDR_W-1:0] o_ss_data,
  input  logic              i_ss_full,
  output logic              o_ss_pop,
  input  logic [ADDR_W-1:0] i_ss_top,
  input  logic              i_ss_empty,
  output logic              o_alarm_valid,
  input  logic              i_alarm_ready,
  output logic [1:0]        o_alarm_cause,
  output logic [ADDR_W-1:0] o_alarm_expected,
  output logic [ADDR_W-1:0] o_alarm_actual,
  output logic [CNT_W-1:0]  o_viol_cnt,
  output logic              o_ovf_sticky
);

  typedef enum logic {
    RUN    = 1'b0,
    REPORT = 1'b1
  } state_e;

  localparam logic [1:0]       CAUSE_NONE      = 2'd0;
  localparam logic [1:0]       CAUSE_MISMATCH  = 2'd1;
  localparam logic [1:0]       CAUSE_UNDERFLOW = 2'd2;
  localparam logic [1:0]       CAUSE_OVERFLOW  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX         = '1;

  state_e            state_q, state_d;
  logic              alarm_valid_q, alarm_valid_d;
  logic [1:0]        cause_q, cause_d;
  logic [ADDR_W-1:0] expected_q, expected_d;
  logic [ADDR_W-1:0] actual_q, actual_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sticky_q, sticky_d;

  logic accept, call_acc, ret_acc;
  logic viol_under, viol_mis, viol_ovf, violation;

  // Every strobe is qualified by accept so undriven event fields never leak out.
  assign o_evt_ready = (state_q == RUN) & rstn;
  assign accept      = i_evt_valid & o_evt_ready;
  assign call_acc    = accept & ~i_evt_is_ret;
  assign ret_acc     = accept & i_evt_is_ret;

  assign o_ss_push   = call_acc & ~i_ss_full;
  assign o_ss_data   = accept ? i_evt_addr : '0;
  assign o_ss_pop    = ret_acc & ~i_ss_empty;

  assign viol_under  = ret_acc & i_ss_empty;
  assign viol_mis    = ret_acc & ~i_ss_empty & (i_ss_top != i_evt_addr);
  assign viol_ovf    = call_acc & i_ss_full & OVF_ALARM;
  assign violation   = viol_under | viol_mis | viol_ovf;

  always_comb begin
    state_d       = state_q;
    alarm_valid_d = alarm_valid_q;
    cause_d       = cause_q;
    expected_d    = expected_q;
    actual_d      = actual_q;
    cnt_d         = cnt_q;
    sticky_d      = sticky_q | (call_acc & i_ss_full);

    if (violation) begin
      state_d       = REPORT;
      alarm_valid_d = 1'b1;
      actual_d      = i_evt_addr;
      expected_d    = viol_mis ? i_ss_top : '0;
      if (viol_mis) begin
        cause_d = CAUSE_MISMATCH;
      end else if (viol_under) begin
        cause_d = CAUSE_UNDERFLOW;
      end else begin
        cause_d = CAUSE_OVERFLOW;
      end
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if ((state_q == REPORT) && alarm_valid_q && i_alarm_ready) begin
      // Address fields are left as-is so software can still read the last report.
      state_d       = RUN;
      alarm_valid_d = 1'b0;
      cause_d       = CAUSE_NONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= RUN;
      alarm_valid_q <= 1'b0;
      cause_q       <= CAUSE_NONE;
      expected_q    <= '0;
      actual_q      <= '0;
      cnt_q         <= '0;
      sticky_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      alarm_valid_q <= alarm_valid_d;
      cause_q       <= cause_d;
      expected_q    <= expected_d;
      actual_q      <= actual_d;
      cnt_q         <= cnt_d;
      sticky_q      <= sticky_d;
    end
  end

  assign o_alarm_valid    = alarm_valid_q;
  assign o_alarm_cause    = cause_q;
  assign o_alarm_expected = expected_q;
  assign o_alarm_actual   = actual_q;
  assign o_viol_cnt       = cnt_q;
  assign o_ovf_sticky     = sticky_q;

endmodule

// File: tb/tb_ras_ss_checker.sv
// Self-checking bench for ras_ss_checker: an 8-deep shadow stack model drives the main DUT,
// a behavioural alarm model is compared every cycle, and directed scenarios pin literal values.
module tb_ras_ss_checker;

  localparam int DEPTH   = 8;
  localparam int CNT_MAX = 3;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        evtValid = 1'b0, evtIsRet = 1'b0, alarmReady = 1'b0;
  logic [63:0] evtAddr = '0;
  logic        ssFull = 1'b0, ssEmpty = 1'b1;
  logic [63:0] ssTop = '0;
  logic        evtReady, ssPush, ssPop, alarmValid, ovfSticky;
  logic [63:0] ssData, alarmExp, alarmAct;
  logic [1:0]  alarmCause, violCnt;

  logic        bValid = 1'b0, bIsRet = 1'b0, bFull = 1'b0, bEmpty = 1'b0, bAlarmRdy = 1'b1;
  logic [63:0] bAddr = '0, bTop = '0;
  logic        bReady, bPush, bPop, bAlarmValid, bSticky;
  logic [63:0] bData, bExp, bAct;
  logic [1:0]  bCause;
  logic [15:0] bCnt;

  int errors = 0;
  int checks = 0;

  logic [63:0] stk[$];
  logic        pendPush = 1'b0, pendPop = 1'b0;
  logic [63:0] pendData = '0;

  logic        mValid = 1'b0, mSticky = 1'b0;
  logic [1:0]  mCause = '0;
  logic [63:0] mExp = '0, mAct = '0;
  int          mCnt = 0;
  logic        eReady, eAcc, ePush, ePop;

  always #5 clk = ~clk;

  ras_ss_checker #(.ADDR_W(64), .CNT_W(2), .OVF_ALARM(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .i_evt_valid(evtValid), .i_evt_is_ret(evtIsRet), .i_evt_addr(evtAddr),
    .o_evt_ready(evtReady), .o_ss_push(ssPush), .o_ss_data(ssData), .i_ss_full(ssFull),
    .o_ss_pop(ssPop), .i_ss_top(ssTop), .i_ss_empty(ssEmpty),
    .o_alarm_valid(alarmValid), .i_alarm_ready(alarmReady), .o_alarm_cause(alarmCause),
    .o_alarm_expected(alarmExp), .o_alarm_actual(alarmAct),
    .o_viol_cnt(violCnt), .o_ovf_sticky(ovfSticky)
  );

  ras_ss_checker #(.ADDR_W(64), .CNT_W(16), .OVF_ALARM(1'b0)) dutB (
    .clk(clk), .rstn(rstn),
    .i_evt_valid(bValid), .i_evt_is_ret(bIsRet), .i_evt_addr(bAddr),
    .o_evt_ready(bReady), .o_ss_push(bPush), .o_ss_data(bData), .i_ss_full(bFull),
    .o_ss_pop(bPop), .i_ss_top(bTop), .i_ss_empty(bEmpty),
    .o_alarm_valid(bAlarmValid), .i_alarm_ready(bAlarmRdy), .o_alarm_cause(bCause),
    .o_alarm_expected(bExp), .o_alarm_actual(bAct),
    .o_viol_cnt(bCnt), .o_ovf_sticky(bSticky)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one event cycle; useTop replaces the address with the live top-of-stack.
  task automatic applyStimulus(input logic v, input logic r, input logic [63:0] a,
                               input logic rdy, input logic useTop);
    @(posedge clk);
    #2;
    evtValid   = v;
    evtIsRet   = r;
    evtAddr    = useTop ? ssTop : a;
    alarmReady = rdy;
  endtask

  task automatic raiseAlarm(input logic [1:0] c, input logic [63:0] e, input logic [63:0] a);
    mValid = 1'b1;
    mCause = c;
    mExp   = e;
    mAct   = a;
    if (mCnt < CNT_MAX) mCnt++;
  endtask

  // Environment shadow stack: applies the strobes the DUT issued in the previous cycle.
  always begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      stk.delete();
    end else begin
      #1;
      if (pendPop && stk.size() > 0) void'(stk.pop_back());
      if (pendPush && stk.size() < DEPTH) stk.push_back(pendData);
    end
    ssFull  = (stk.size() >= DEPTH);
    ssEmpty = (stk.size() == 0);
    ssTop   = ssEmpty ? 64'd0 : stk[stk.size()-1];
  end

  // Reference model and per-cycle comparison for the main DUT.
  always @(negedge clk) begin
    if (!rstn) begin
      mValid = 1'b0; mCause = '0; mExp = '0; mAct = '0; mCnt = 0; mSticky = 1'b0;
    end
    eReady = rstn && !mValid;
    eAcc   = evtValid && eReady;
    ePush  = eAcc && !evtIsRet && !ssFull;
    ePop   = eAcc && evtIsRet && !ssEmpty;
    checkOutput("evt_ready", evtReady, eReady);
    checkOutput("ss_push", ssPush, ePush);
    checkOutput("ss_pop", ssPop, ePop);
    if (ePush) checkOutput("ss_data", ssData, evtAddr);
    checkOutput("alarm_valid", alarmValid, mValid);
    checkOutput("alarm_cause", alarmCause, mCause);
    checkOutput("alarm_expected", alarmExp, mExp);
    checkOutput("alarm_actual", alarmAct, mAct);
    checkOutput("viol_cnt", violCnt, mCnt);
    checkOutput("ovf_sticky", ovfSticky, mSticky);
    pendPush = ssPush;
    pendPop  = ssPop;
    pendData = ssData;
    if (rstn) begin
      if (eAcc && evtIsRet && ssEmpty) begin
        raiseAlarm(2'd2, 64'd0, evtAddr);
      end else if (eAcc && evtIsRet && (ssTop != evtAddr)) begin
        raiseAlarm(2'd1, ssTop, evtAddr);
      end else if (eAcc && !evtIsRet && ssFull) begin
        mSticky = 1'b1;
        raiseAlarm(2'd3, 64'd0, evtAddr);
      end else if (mValid && alarmReady) begin
        mValid = 1'b0;
        mCause = 2'd0;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset alarm_valid", alarmValid, 0);
    checkOutput("reset viol_cnt", violCnt, 0);
    checkOutput("reset evt_ready", evtReady, 0);
    @(posedge clk);
    #2 rstn = 1'b1;

    // Balanced calls and returns.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 1'b0, 64'h100 * i, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("t1 push", ssPush, 1);
      checkOutput("t1 data", ssData, 64'h100 * i);
    end
    for (int i = 3; i >= 1; i--) begin
      applyStimulus(1'b1, 1'b1, 64'h100 * i, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("t1 pop", ssPop, 1);
      checkOutput("t1 ready", evtReady, 1);
    end
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t1 no alarm", alarmValid, 0);
    checkOutput("t1 cnt", violCnt, 0);

    // Mismatching return, then a held alarm with events pending.
    applyStimulus(1'b1, 1'b0, 64'h100, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 64'h104, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t2 pop", ssPop, 1);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t2 valid", alarmValid, 1);
    checkOutput("t2 cause", alarmCause, 1);
    checkOutput("t2 expected", alarmExp, 64'h100);
    checkOutput("t2 actual", alarmAct, 64'h104);
    checkOutput("t2 cnt", violCnt, 1);
    checkOutput("t2 ready", evtReady, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 64'h999, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t5 push", ssPush, 0);
      checkOutput("t5 ready", evtReady, 0);
      checkOutput("t5 cause", alarmCause, 1);
      checkOutput("t5 actual", alarmAct, 64'h104);
    end
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t5 valid at handshake", alarmValid, 1);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t5 valid after", alarmValid, 0);
    checkOutput("t5 cause after", alarmCause, 0);
    checkOutput("t5 ready after", evtReady, 1);
    checkOutput("t5 expected kept", alarmExp, 64'h100);

    // Return on an empty stack.
    applyStimulus(1'b1, 1'b1, 64'h40, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t3 no pop", ssPop, 0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t3 cause", alarmCause, 2);
    checkOutput("t3 expected", alarmExp, 0);
    checkOutput("t3 actual", alarmAct, 64'h40);
    checkOutput("t3 cnt", violCnt, 2);
    applyStimulus(1'b1, 1'b0, 64'h50, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t3 push after", ssPush, 1);
    applyStimulus(1'b1, 1'b1, 64'h50, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t3 pop match", ssPop, 1);

    // Full stack with the overflow alarm disabled.
    @(posedge clk);
    #2 bValid = 1'b1; bFull = 1'b0; bAddr = 64'h70;
    evtValid = 1'b0;
    @(negedge clk);
    checkOutput("b push", bPush, 1);
    checkOutput("b sticky before", bSticky, 0);
    @(posedge clk);
    #2 bFull = 1'b1; bAddr = 64'h77;
    @(negedge clk);
    checkOutput("b no push", bPush, 0);
    @(posedge clk);
    #2 bValid = 1'b0;
    @(negedge clk);
    checkOutput("b no alarm", bAlarmValid, 0);
    checkOutput("b sticky", bSticky, 1);
    checkOutput("b cnt", bCnt, 0);
    checkOutput("b ready", bReady, 1);
    checkOutput("b pop", bPop, 0);
    checkOutput("b expected", bExp, 0);
    checkOutput("b actual", bAct, 0);
    checkOutput("b data", bData, 0);
    checkOutput("b cause", bCause, 0);

    // Ninth call into an 8-deep stack with the overflow alarm enabled.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b0, 64'h1000 + 64'(8 * i), 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("t4 push", ssPush, (i < 8) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t4 cause", alarmCause, 3);
    checkOutput("t4 expected", alarmExp, 0);
    checkOutput("t4 actual", alarmAct, 64'h1040);
    checkOutput("t4 sticky", ovfSticky, 1);
    checkOutput("t4 cnt", violCnt, 3);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 64'h0, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("t4 drain pop", ssPop, 1);
    end

    // Counter saturation with repeated mismatches.
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 1'b0, 64'(16 * k), 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 64'(16 * k + 4), 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("t6 cause", alarmCause, 1);
      checkOutput("t6 cnt", violCnt, 3);
    end

    // Reset dropped while an alarm is pending.
    applyStimulus(1'b1, 1'b1, 64'h44, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t6 in report", alarmValid, 1);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    checkOutput("t6 async valid", alarmValid, 0);
    checkOutput("t6 async cause", alarmCause, 0);
    checkOutput("t6 async cnt", violCnt, 0);
    checkOutput("t6 async sticky", ovfSticky, 0);
    checkOutput("t6 async actual", alarmAct, 0);
    checkOutput("t6 async ready", evtReady, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rstn = 1'b1;

    // Randomised traffic against the model.
    for (int n = 0; n < 2500; n++) begin
      logic v, r, rdy, useTop;
      logic [63:0] a;
      v      = ($urandom_range(0, 9) < 7);
      r      = ($urandom_range(0, 99) < 45);
      useTop = r && ($urandom_range(0, 3) != 0);
      a      = {32'h0, $urandom} & 64'hFFF0;
      rdy    = $urandom_range(0, 1) == 1;
      applyStimulus(v, r, a, rdy, useTop);
    end
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
